// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the WB/MDU/issue/hazard sources and the register-file write-port arbiter.
// The master side drives the sources; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int N     = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [N-1:0]  wb_data;
  logic          mdu_valid;
  logic [4:0]    mdu_rd;
  logic [N-1:0]  mdu_data;
  logic          mdu_ready;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic          rs1_pending;
  logic          rs2_pending;
  logic          rf_regwrite;
  logic [4:0]    rf_writereg;
  logic [N-1:0]  rf_writedata;
  logic [CW-1:0] fifo_count;
  logic          waw_err;

  modport master (
    output wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
           issue_valid, issue_rd, rs1, rs2,
    input  mdu_ready, rs1_pending, rs2_pending, rf_regwrite, rf_writereg,
           rf_writedata, fifo_count, waw_err
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
           issue_valid, issue_rd, rs1, rs2,
    output mdu_ready, rs1_pending, rs2_pending, rf_regwrite, rf_writereg,
           rf_writedata, fifo_count, waw_err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WB always wins, MDU results queue in a FIFO and
// drain in idle WB cycles; a scoreboard tracks registers with MDU results outstanding.
module regfile_wb_arbiter #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N+4:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pending;
  logic [31:0]   pending_next;
  logic          regwrite;
  logic [4:0]    writereg;
  logic [N-1:0]  writedata;
  logic          waw;

  logic          wb_sel;
  logic          empty;
  logic          full;
  logic          pop;
  logic          bypass;
  logic          push;
  logic [4:0]    head_rd;
  logic [N-1:0]  head_data;

  assign {head_rd, head_data} = mem[rd_ptr];
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign wb_sel = bus.wb_valid && (bus.wb_rd != 5'd0);
  assign pop    = !wb_sel && !empty;
  assign bypass = !wb_sel && empty && bus.mdu_valid && (bus.mdu_rd != 5'd0);
  // x0 results are still handshaken so the MDU can retire them; they just never land.
  assign push   = bus.mdu_valid && !full && (bus.mdu_rd != 5'd0) && !bypass;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.mdu_rd, bus.mdu_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Set beats clear when an issue and a retire hit the same register together.
  always_comb begin
    pending_next = pending;
    if (pop)
      pending_next[head_rd] = 1'b0;
    else if (bypass)
      pending_next[bus.mdu_rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0))
      pending_next[bus.issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      waw       <= 1'b0;
      regwrite  <= 1'b0;
      writereg  <= '0;
      writedata <= '0;
    end else begin
      pending  <= pending_next;
      waw      <= waw | (wb_sel && pending[bus.wb_rd]);
      regwrite <= wb_sel | pop | bypass;
      if (wb_sel) begin
        writereg  <= bus.wb_rd;
        writedata <= bus.wb_data;
      end else if (pop) begin
        writereg  <= head_rd;
        writedata <= head_data;
      end else if (bypass) begin
        writereg  <= bus.mdu_rd;
        writedata <= bus.mdu_data;
      end
    end
  end

  assign bus.mdu_ready    = !full;
  assign bus.rs1_pending  = pending[bus.rs1];
  assign bus.rs2_pending  = pending[bus.rs2];
  assign bus.rf_regwrite  = regwrite;
  assign bus.rf_writereg  = writereg;
  assign bus.rf_writedata = writedata;
  assign bus.fifo_count   = count;
  assign bus.waw_err      = waw;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic
// compared against a queue-based behavioural model of the write-port rules.
module tb_regfile_wb_arbiter;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N(N), .DEPTH(DEPTH)) bus ();
  regfile_wb_arbiter #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Model state: buffered MDU results, scoreboard, registered output stage.
  logic [36:0] mq[$];
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        m_waw;
  // MDU result source: head is presented and held until accepted.
  logic [36:0] src[$];

  function automatic logic [42:0] dut_obs();
    return {bus.rf_regwrite, bus.rf_writereg, bus.rf_writedata, bus.fifo_count,
            bus.mdu_ready, bus.waw_err};
  endfunction

  function automatic logic [42:0] mdl_obs();
    logic rdy;
    rdy = (mq.size() < DEPTH);
    return {m_we, m_reg, m_data, 3'(mq.size()), rdy, m_waw};
  endfunction

  task automatic idle_inputs();
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  task automatic drive_mdu();
    bus.mdu_valid = (src.size() != 0);
    if (src.size() != 0) {bus.mdu_rd, bus.mdu_data} = src[0];
  endtask

  task automatic model_reset();
    mq.delete(); src.delete();
    m_pend = '0; m_we = 1'b0; m_reg = '0; m_data = '0; m_waw = 1'b0;
  endtask

  // Apply one clock of the current inputs to both the model and the DUT.
  task automatic tick();
    logic [36:0] head;
    bit wbw, byp, rdy;
    rdy = (mq.size() < DEPTH);
    wbw = bus.wb_valid && (bus.wb_rd != 5'd0);
    byp = 1'b0;
    m_we = 1'b0;
    if (wbw) begin
      if (m_pend[bus.wb_rd]) m_waw = 1'b1;
      m_we = 1'b1; m_reg = bus.wb_rd; m_data = bus.wb_data;
    end else if (mq.size() != 0) begin
      head = mq.pop_front();
      m_we = 1'b1; m_reg = head[36:32]; m_data = head[31:0];
      m_pend[head[36:32]] = 1'b0;
    end else if (bus.mdu_valid && (bus.mdu_rd != 5'd0)) begin
      byp = 1'b1;
      m_we = 1'b1; m_reg = bus.mdu_rd; m_data = bus.mdu_data;
      m_pend[bus.mdu_rd] = 1'b0;
    end
    if (bus.mdu_valid && rdy) begin
      if ((bus.mdu_rd != 5'd0) && !byp) mq.push_back({bus.mdu_rd, bus.mdu_data});
      if (src.size() != 0) void'(src.pop_front());
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) m_pend[bus.issue_rd] = 1'b1;
    @(posedge clk); #1;
    drive_mdu();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    drive_mdu();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (dut_obs() !== 43'd2) begin
      miscompares++;
      $display("FAIL reset_state: got %h exp %h", dut_obs(), 43'd2);
    end
    for (int r = 0; r < 32; r += 8) begin
      bus.rs1 = 5'(r); bus.rs2 = 5'(r + 3); #1;
      vectors++;
      if ({bus.rs1_pending, bus.rs2_pending} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_pending r%0d: got %b exp 00", r, {bus.rs1_pending, bus.rs2_pending});
      end
    end
    idle_inputs();
  endtask

  task automatic test_wb_write();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    vectors++;
    if ({bus.rf_regwrite, bus.rf_writereg, bus.rf_writedata} !== {1'b1, 5'd5, 32'hA5A5A5A5}) begin
      miscompares++;
      $display("FAIL wb_write: got %b/%0d/%h exp 1/5/a5a5a5a5",
               bus.rf_regwrite, bus.rf_writereg, bus.rf_writedata);
    end
    tick();
    vectors++;
    if (dut_obs() !== mdl_obs() || bus.rf_regwrite !== 1'b0) begin
      miscompares++;
      $display("FAIL wb_pulse: got %h exp %h", dut_obs(), mdl_obs());
    end
  endtask

  task automatic test_bypass();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_valid = 1'b0;
    bus.rs1 = 5'd7; #1;
    vectors++;
    if (bus.rs1_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_pend_set: got %b exp 1", bus.rs1_pending);
    end
    src.push_back({5'd7, 32'h12});
    drive_mdu();
    tick();
    vectors++;
    if ({bus.rf_regwrite, bus.rf_writereg, bus.rf_writedata, bus.rs1_pending, bus.fifo_count}
        !== {1'b1, 5'd7, 32'h12, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL bypass_write: got %b/%0d/%h pend=%b cnt=%0d exp 1/7/12 pend=0 cnt=0",
               bus.rf_regwrite, bus.rf_writereg, bus.rf_writedata, bus.rs1_pending, bus.fifo_count);
    end
    idle_inputs();
  endtask

  task automatic test_backlog();
    for (int k = 0; k < 5; k++) src.push_back({5'(k + 1), 32'h100 + 32'(k)});
    drive_mdu();
    for (int i = 0; i < 6; i++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'(10 + i); bus.wb_data = 32'hBEEF0000 + 32'(i);
      #1;
      if (i == 4) begin
        vectors++;
        if (bus.mdu_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
          miscompares++;
          $display("FAIL backlog_full: ready=%b cnt=%0d exp ready=0 cnt=4", bus.mdu_ready, bus.fifo_count);
        end
      end
      tick();
      vectors++;
      if (dut_obs() !== mdl_obs()) begin
        miscompares++;
        $display("FAIL backlog_wb c%0d: got %h exp %h", i, dut_obs(), mdl_obs());
      end
    end
    idle_inputs();
    for (int j = 0; j < 5; j++) begin
      tick();
      vectors++;
      if ({bus.rf_regwrite, bus.rf_writereg, bus.rf_writedata} !== {1'b1, 5'(j + 1), 32'h100 + 32'(j)}) begin
        miscompares++;
        $display("FAIL backlog_drain d%0d: got %b/%0d/%h exp 1/%0d/%h", j, bus.rf_regwrite,
                 bus.rf_writereg, bus.rf_writedata, j + 1, 32'h100 + 32'(j));
      end
    end
    vectors++;
    if (bus.fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL backlog_empty: cnt=%0d exp 0", bus.fifo_count);
    end
  endtask

  task automatic test_full_stream();
    logic [36:0] expq[$];
    logic [36:0] got[$];
    logic [36:0] item;
    for (int k = 0; k < 12; k++) begin
      item = {5'($urandom_range(1, 31)), 32'($urandom())};
      src.push_back(item);
      expq.push_back(item);
    end
    drive_mdu();
    for (int i = 0; i < 4; i++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd20; bus.wb_data = 32'(i);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.rf_regwrite === 1'b1) got.push_back({bus.rf_writereg, bus.rf_writedata});
      vectors++;
      if (dut_obs() !== mdl_obs()) begin
        miscompares++;
        $display("FAIL stream_obs c%0d: got %h exp %h", i, dut_obs(), mdl_obs());
      end
    end
    vectors++;
    if (got.size() != expq.size()) begin
      miscompares++;
      $display("FAIL stream_len: got %0d exp %0d", got.size(), expq.size());
    end
    for (int k = 0; k < got.size() && k < expq.size(); k++) begin
      vectors++;
      if (got[k] !== expq[k]) begin
        miscompares++;
        $display("FAIL stream_order k%0d: got %h exp %h", k, got[k], expq[k]);
      end
    end
  endtask

  task automatic test_x0();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    tick();
    vectors++;
    if (bus.rf_regwrite !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_wb: regwrite=%b exp 0", bus.rf_regwrite);
    end
    bus.wb_valid = 1'b0;
    src.push_back({5'd0, 32'hDEAD0000});
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    drive_mdu();
    tick();
    bus.issue_valid = 1'b0; bus.rs1 = 5'd0; bus.rs2 = 5'd0; #1;
    vectors++;
    if ({bus.rf_regwrite, bus.fifo_count, bus.mdu_valid, bus.rs1_pending, bus.rs2_pending}
        !== {1'b0, 3'd0, 1'b0, 2'b00}) begin
      miscompares++;
      $display("FAIL x0_mdu: regwrite=%b cnt=%0d valid=%b pend=%b%b exp 0/0/0/00", bus.rf_regwrite,
               bus.fifo_count, bus.mdu_valid, bus.rs1_pending, bus.rs2_pending);
    end
    // A WB to x0 must not stall the drain of a buffered result.
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h1;
    src.push_back({5'd4, 32'h44}); drive_mdu();
    tick();
    bus.wb_rd = 5'd0;
    tick();
    vectors++;
    if ({bus.rf_regwrite, bus.rf_writereg, bus.rf_writedata} !== {1'b1, 5'd4, 32'h44}) begin
      miscompares++;
      $display("FAIL x0_drain: got %b/%0d/%h exp 1/4/44", bus.rf_regwrite, bus.rf_writereg, bus.rf_writedata);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.wb_valid = ($urandom_range(0, 1) == 1);
      bus.wb_rd = 5'($urandom_range(0, 31)); bus.wb_data = $urandom();
      bus.issue_valid = ($urandom_range(0, 3) == 0);
      bus.issue_rd = 5'($urandom_range(0, 31));
      bus.rs1 = 5'($urandom_range(0, 31)); bus.rs2 = 5'($urandom_range(0, 31));
      if (src.size() < 2 && $urandom_range(0, 1) == 1)
        src.push_back({5'($urandom_range(0, 31)), 32'($urandom())});
      drive_mdu();
      #1;
      vectors++;
      if ({bus.mdu_ready, bus.rs1_pending, bus.rs2_pending}
          !== {logic'(mq.size() < DEPTH), m_pend[bus.rs1], m_pend[bus.rs2]}) begin
        miscompares++;
        $display("FAIL rand_comb c%0d: got %b%b%b exp %b%b%b", c, bus.mdu_ready, bus.rs1_pending,
                 bus.rs2_pending, mq.size() < DEPTH, m_pend[bus.rs1], m_pend[bus.rs2]);
      end
      tick();
      vectors++;
      if (dut_obs() !== mdl_obs()) begin
        miscompares++;
        $display("FAIL rand_obs c%0d: got %h exp %h", c, dut_obs(), mdl_obs());
      end
    end
    idle_inputs();
  endtask

  task automatic test_waw();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    vectors++;
    if (bus.waw_err !== 1'b0) begin
      miscompares++;
      $display("FAIL waw_pre: got %b exp 0", bus.waw_err);
    end
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h99;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.waw_err !== 1'b1) begin
        miscompares++;
        $display("FAIL waw_sticky c%0d: got %b exp 1", i, bus.waw_err);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) src.push_back({5'(k + 11), 32'h300 + 32'(k)});
    drive_mdu();
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd21; bus.wb_data = 32'(i);
      tick();
    end
    vectors++;
    if (bus.fifo_count !== 3'd3) begin
      miscompares++;
      $display("FAIL midrst_fill: cnt=%0d exp 3", bus.fifo_count);
    end
    rst_n = 1'b0;
    bus.rs1 = 5'd9; bus.rs2 = 5'd7;
    #1;
    vectors++;
    if ({bus.fifo_count, bus.rf_regwrite, bus.waw_err, bus.mdu_ready, bus.rs1_pending}
        !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_clear: cnt=%0d we=%b waw=%b rdy=%b pend=%b exp 0/0/0/1/0", bus.fifo_count,
               bus.rf_regwrite, bus.waw_err, bus.mdu_ready, bus.rs1_pending);
    end
    idle_inputs();
    model_reset();
    drive_mdu();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dut_obs() !== mdl_obs()) begin
        miscompares++;
        $display("FAIL midrst_after c%0d: got %h exp %h", i, dut_obs(), mdl_obs());
      end
    end
  endtask

  initial begin
    idle_inputs();
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
    model_reset();
    test_reset();
    test_wb_write();
    test_bypass();
    test_backlog();
    test_full_stream();
    test_x0();
    test_random();
    apply_reset();
    test_waw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
